cdc_handshake_sender: RTL

Source-side controller for a 4-phase req/ack clock-domain-crossing handshake. It accepts a word on a local valid/ready interface and holds it stable on a transfer bus. It raises a request, then sequences the request against the remote acknowledge, which it brings in through an internal flip-flop synchronizer. It sits in the sending clock domain, paired with a receiver that samples `xfer_data` once it sees `xfer_req` high.

---
 rtl/cdc_handshake_sender_if.sv | 24 ++
 rtl/cdc_handshake_sender.sv | 116 +++++++++++
 2 files changed

// File: rtl/cdc_handshake_sender_if.sv
// Local word interface plus the req/ack transfer bus of the CDC handshake sender.
// master: the sender block; slave: the surrounding logic and the remote receiver.
interface cdc_handshake_sender_if #(
    parameter int width = 8
);
    logic [width-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [width-1:0] xfer_data;
    logic             xfer_req;
    logic             xfer_ack;
    logic             busy;
    logic             timeout;

    modport master (
        input  din, din_valid, xfer_ack,
        output din_ready, xfer_data, xfer_req, busy, timeout
    );

    modport slave (
        output din, din_valid, xfer_ack,
        input  din_ready, xfer_data, xfer_req, busy, timeout
    );
endinterface

// File: rtl/cdc_handshake_sender.sv
// Source side of a 4-phase req/ack CDC handshake; optional phase timeout under CDC_HS_TIMEOUT_EN.
// Latency: req/data valid right after the accept edge; a full loopback cycle is 2*stages+3 edges.
// Backpressure: din_ready is high only in IDLE; the word is held until the handshake completes.
module cdc_handshake_sender #(
    parameter int width          = 8,
    parameter int stages         = 2,
    parameter int timeout_cycles = 1023
) (
    input  logic                  clock,
    input  logic                  reset_n,
    cdc_handshake_sender_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ_HIGH, REQ_LOW} state_t;

    state_t            state_q, state_d;
    logic [width-1:0]  data_q, data_d;
    logic              req_q, req_d;
    logic              timeout_q, timeout_d;
    logic [stages-1:0] sync_q, sync_d;
    logic              ack_s;
    logic              tmo_hit;

    assign sync_d = {sync_q[stages-2:0], bus.xfer_ack};
    assign ack_s  = sync_q[stages-1];

`ifdef CDC_HS_TIMEOUT_EN
    localparam int cnt_w = $clog2(timeout_cycles + 1);
    logic [cnt_w-1:0] cnt_q, cnt_d;

    assign tmo_hit = (cnt_q == cnt_w'(timeout_cycles));

    // Any state change restarts the phase count, so it never runs past the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (timeout_cycles > 0);
    assign tmo_hit        = 1'b0;
`endif

    // An acknowledge that arrives together with the limit wins, so no pulse is raised.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        req_d     = req_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (bus.din_valid) begin
                    data_d  = bus.din;
                    req_d   = 1'b1;
                    state_d = REQ_HIGH;
                end
            end
            REQ_HIGH: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LOW;
                end else if (tmo_hit) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = REQ_LOW;
                end
            end
            REQ_LOW: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            req_q     <= 1'b0;
            timeout_q <= 1'b0;
            sync_q    <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            req_q     <= req_d;
            timeout_q <= timeout_d;
            sync_q    <= sync_d;
        end
    end

    assign bus.din_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.xfer_data = data_q;
    assign bus.xfer_req  = req_q;
    assign bus.timeout   = timeout_q;
endmodule
